alu_operand_stage: RTL and testbench

- Decode/issue stage directly upstream of the ALU: holds the 32x32 register file, reads two operands, selects an immediate, and registers {read_data1, read_data2, func, rd} into the ALU input pipeline register.
- Valid/ready handshake on both sides.
- Resolves RAW hazards against the instruction currently at the ALU (forwarding or interlock) and against the writeback port (same-cycle bypass).

---
 rtl/alu_operand_stage.sv | 139 +++++++++++++
 tb/tb_alu_operand_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand fetch/issue stage ahead of the ALU: 32-entry register file, operand select, ALU input register.
// Build option ALU_FWD_EN: forward alu_result into operands instead of interlocking on RAW hazards.
module alu_operand_stage #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  input  logic [AW-1:0] in_rd,
  input  logic          in_rd_we,
  input  logic          in_use_imm,
  input  logic [DW-1:0] in_imm,
  input  logic [3:0]    in_func,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] read_data1,
  output logic [DW-1:0] read_data2,
  output logic [3:0]    func,
  output logic [AW-1:0] out_rd,
  output logic          out_rd_we,
  input  logic [DW-1:0] alu_result,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data
);

  localparam int unsigned FW = 4;

  logic [DW-1:0] r_rf [NREGS];

  logic          r_out_valid;
  logic [DW-1:0] r_rd1;
  logic [DW-1:0] r_rd2;
  logic [FW-1:0] r_func;
  logic [AW-1:0] r_rd;
  logic          r_rd_we;

  logic          w_hazard;
  logic          w_accept;
  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_op2;

`ifdef ALU_FWD_EN
  logic          w_fwd_ok;

  // The held instruction's result is visible combinationally, so a dependent read never stalls.
  assign w_fwd_ok = r_out_valid && r_rd_we;
  assign w_hazard = 1'b0;
`else
  logic          w_unused;

  // Without a forward path, wait until the producer leaves; its writeback then lands via the bypass.
  assign w_unused = ^alu_result;
  assign w_hazard = r_out_valid && r_rd_we && (r_rd != '0) &&
                    ((r_rd == in_rs) || (!in_use_imm && (r_rd == in_rt)));
`endif

  assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
  assign w_accept = in_valid && in_ready;

  // Operand 1: zero register, then forward, then writeback bypass, then register file.
  always_comb begin
    w_op1 = r_rf[in_rs];
    if (in_rs == '0) begin
      w_op1 = '0;
    end
`ifdef ALU_FWD_EN
    else if (w_fwd_ok && (r_rd == in_rs)) begin
      w_op1 = alu_result;
    end
`endif
    else if (wb_en && (wb_addr == in_rs)) begin
      w_op1 = wb_data;
    end
  end

  // Operand 2: immediate overrides rt; otherwise same priority as operand 1.
  always_comb begin
    w_op2 = r_rf[in_rt];
    if (in_use_imm) begin
      w_op2 = in_imm;
    end else if (in_rt == '0) begin
      w_op2 = '0;
    end
`ifdef ALU_FWD_EN
    else if (w_fwd_ok && (r_rd == in_rt)) begin
      w_op2 = alu_result;
    end
`endif
    else if (wb_en && (wb_addr == in_rt)) begin
      w_op2 = wb_data;
    end
  end

  // Register file; r0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (wb_en && (wb_addr != '0)) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // ALU input register; payload is held once consumed until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_rd1       <= '0;
      r_rd2       <= '0;
      r_func      <= '0;
      r_rd        <= '0;
      r_rd_we     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_rd1       <= w_op1;
      r_rd2       <= w_op2;
      r_func      <= in_func;
      r_rd        <= in_rd;
      r_rd_we     <= in_rd_we;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign read_data1 = r_rd1;
  assign read_data2 = r_rd2;
  assign func       = r_func;
  assign out_rd     = r_rd;
  assign out_rd_we  = r_rd_we;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed issues push expected operands, a monitor checks on consume.
module tb_alu_operand_stage;

`ifdef ALU_FWD_EN
  localparam int EXP_RAW_STALL = 0;
`else
  localparam int EXP_RAW_STALL = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic [3:0]  in_func;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [3:0]  func;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] alu_result;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [3:0]  f;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;
  int   n_pop  = 0;

  alu_operand_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_rd_we   (in_rd_we),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .in_func    (in_func),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .func       (func),
    .out_rd     (out_rd),
    .out_rd_we  (out_rd_we),
    .alu_result (alu_result),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one instruction, wait (bounded) for acceptance, push its expected operands.
  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic we, input logic ui, input logic [31:0] imm,
                       input logic [3:0] f, input logic [31:0] e1, input logic [31:0] e2,
                       output int stalls);
    exp_t e;
    bit   ok;
    in_rs = rs; in_rt = rt; in_rd = rd; in_rd_we = we;
    in_use_imm = ui; in_imm = imm; in_func = f; in_valid = 1'b1;
    stalls = 0;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (ok) begin
      e.d1 = e1; e.d2 = e2; e.f = f; e.rd = rd; e.we = we;
      q.push_back(e);
      n_push++;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %b for rs=%0d", in_ready, rs);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every consume must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_pop++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got d1=%h d2=%h with empty scoreboard", read_data1, read_data2);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_rd1", read_data1, e.d1);
        chk("sb_rd2", read_data2, e.d2);
        chk("sb_func", 32'(func), 32'(e.f));
        chk("sb_rd", 32'(out_rd), 32'(e.rd));
        chk("sb_rd_we", 32'(out_rd_we), 32'(e.we));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    rst_n = 1'b0; in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_rd_we = 1'b0;
    in_use_imm = 1'b0; in_imm = '0; in_func = '0; out_ready = 1'b1;
    alu_result = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_rd1", read_data1, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while an instruction is held in the output register.
    wb_write(5'd5, 32'h0000_0055);
    out_ready = 1'b0;
    issue(5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 32'd0, 4'h3, 32'h55, 32'h0, st);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    chk("pre_reset_rd1", read_data1, 32'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_rd1", read_data1, 32'd0);
    chk("async_rst_rd2", read_data2, 32'd0);
    chk("async_rst_func", 32'(func), 32'd0);
    chk("async_rst_rd", 32'(out_rd), 32'd0);
    chk("async_rst_rd_we", 32'(out_rd_we), 32'd0);
    q.delete();
    n_push = 0;
    n_pop = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    issue(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 4'h0, 32'h0, 32'h0, st);

    // Basic register reads.
    wb_write(5'd3, 32'h0000_0010);
    wb_write(5'd4, 32'h0000_0005);
    issue(5'd3, 5'd4, 5'd1, 1'b1, 1'b0, 32'd0, 4'h1, 32'h10, 32'h5, st);

    // r0 write ignored and immediate operand, with a concurrent r0 writeback.
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    issue(5'd0, 5'd4, 5'd6, 1'b1, 1'b1, 32'hFFFF_FFF8, 4'h2, 32'h0, 32'hFFFF_FFF8, st);
    wb_en = 1'b0;
    issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 4'h0, 32'h0, 32'h0, st);

    // Same-cycle writeback bypass, then the same value from the register file.
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5_A5A5;
    issue(5'd7, 5'd0, 5'd8, 1'b0, 1'b0, 32'd0, 4'h4, 32'hA5A5_A5A5, 32'h0, st);
    wb_en = 1'b0;
    issue(5'd3, 5'd7, 5'd8, 1'b0, 1'b0, 32'd0, 4'h5, 32'h10, 32'hA5A5_A5A5, st);

    // Back-to-back RAW on r2; writeback follows the consume by one cycle.
    issue(5'd3, 5'd4, 5'd2, 1'b1, 1'b0, 32'd0, 4'h0, 32'h10, 32'h5, st);
    alu_result = 32'h0000_0030;
    fork
      issue(5'd2, 5'd0, 5'd10, 1'b0, 1'b0, 32'd0, 4'h6, 32'h30, 32'h0, st);
      begin
        @(posedge clk); #1;
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_0030;
        @(posedge clk); #1;
        wb_en = 1'b0;
      end
    join
    alu_result = 32'd0;
    chk("raw_stall_cycles", 32'(st), 32'(EXP_RAW_STALL));
    issue(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 4'h0, 32'h30, 32'h0, st);

    // rt of an immediate instruction and a write to r0 are not hazards.
    issue(5'd3, 5'd4, 5'd9, 1'b1, 1'b0, 32'd0, 4'h0, 32'h10, 32'h5, st);
    issue(5'd4, 5'd9, 5'd0, 1'b0, 1'b1, 32'h0000_1234, 4'h8, 32'h5, 32'h1234, st);
    chk("imm_rt_no_stall", 32'(st), 32'd0);
    issue(5'd3, 5'd4, 5'd0, 1'b1, 1'b0, 32'd0, 4'h0, 32'h10, 32'h5, st);
    issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 4'h9, 32'h0, 32'h0, st);
    chk("r0_dest_no_stall", 32'(st), 32'd0);

    // Backpressure: hold A for three cycles while B waits, then stream B, C, D.
    idle(1);
    out_ready = 1'b0;
    issue(5'd3, 5'd4, 5'd11, 1'b0, 1'b0, 32'd0, 4'hF, 32'h10, 32'h5, st);
    in_rs = 5'd4; in_rt = 5'd3; in_rd = 5'd12; in_rd_we = 1'b0;
    in_use_imm = 1'b0; in_func = 4'h7; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_rd1_stable", read_data1, 32'h10);
      chk("bp_func_stable", 32'(func), 32'hF);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(5'd4, 5'd3, 5'd12, 1'b0, 1'b0, 32'd0, 4'h7, 32'h5, 32'h10, st);
    chk("bp_resume_b", 32'(st), 32'd0);
    issue(5'd7, 5'd2, 5'd13, 1'b0, 1'b0, 32'd0, 4'hA, 32'hA5A5_A5A5, 32'h30, st);
    chk("bp_resume_c", 32'(st), 32'd0);
    issue(5'd2, 5'd0, 5'd14, 1'b0, 1'b1, 32'h0000_0077, 4'hB, 32'h30, 32'h77, st);
    chk("bp_resume_d", 32'(st), 32'd0);

    idle(3);
    chk("sb_empty", 32'(q.size()), 32'd0);
    chk("transfer_count", 32'(n_pop), 32'(n_push));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
